// File: rtl/key_evt_pkg.sv
// Shared widths, event field positions and the priority-select helper
// used by the keypad event encoder.
package key_evt_pkg;

  localparam int KEY_W        = 4;
  localparam int NKEYS        = 16;
  localparam int EV_W         = 5;
  localparam int EV_PRESS_BIT = 4;

  // Lowest-index set bit of v; callers qualify the result with |v.
  function automatic logic [KEY_W-1:0] lowest_set(input logic [NKEYS-1:0] v);
    lowest_set = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_evt_enc_fifo.sv
// Synchronous show-ahead FIFO: head is the oldest entry, zero when empty.
// Pointers carry one extra wrap bit so full/empty are distinguishable.
module evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_evt_enc.sv
// Turns the debounced key-level bitmap into serialized press/release events.
// Build option KEY_EVT_RELEASE_EN: when defined, releases are queued too.
module key_evt_enc
  import key_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     btn,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [EV_W-1:0] ev_code,
  output logic            busy,
  output logic [4:0]      pressed_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [NKEYS-1:0] btn_q;
  logic [NKEYS-1:0] rep;
  logic [NKEYS-1:0] pending;
  logic [KEY_W-1:0] sel_key;
  logic             sel_press;
  logic             has_sel;
  logic             need_push;
  logic             space_ok;
  logic             take;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;

  // Stage 0: register the level vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn;
  end

  // Stage 1: select the lowest pending key and report it
  assign pending   = btn_q ^ rep;
  assign busy      = |pending;
  assign has_sel   = |pending;
  assign sel_key   = lowest_set(pending);
  assign sel_press = btn_q[sel_key];
  assign pop       = ev_valid & ev_ready;
  assign space_ok  = (int'(fifo_count) < DEPTH) || (fifo_full && pop);

`ifdef KEY_EVT_RELEASE_EN
  assign need_push = has_sel;
`else
  // Releases only retire the pending bit; they never wait for FIFO space.
  assign need_push = has_sel & sel_press;
`endif

  assign take = has_sel & (~need_push | space_ok);
  assign push = need_push & space_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep         <= '0;
      pressed_cnt <= '0;
    end else if (take) begin
      rep[sel_key] <= sel_press;
      pressed_cnt  <= sel_press ? pressed_cnt + 5'd1 : pressed_cnt - 5'd1;
    end
  end

  // Stage 2: event queue toward the consumer
  evt_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({sel_press, sel_key}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (ev_code)
  );

  assign ev_valid = ~fifo_empty;

endmodule
